fir_y_out_fifo: RTL



---
 rtl/fir_y_out_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fir_y_out_fifo.sv
// Output buffer behind the FIR AXI-Stream master: small register FIFO plus
// per-frame statistics (frame count, last frame length, additive checksum).
module fir_y_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pLVL_WIDTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   clear,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [pLVL_WIDTH-1:0]  level,
  output logic [15:0]            frame_cnt,
  output logic [31:0]            last_len,
  output logic [31:0]            last_sum,
  output logic                   frame_done
);

  localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [pLVL_WIDTH-1:0] LVL_FULL = pLVL_WIDTH'(pDEPTH);

  logic [pDATA_WIDTH:0]  mem_q [pDEPTH];
  logic [pDATA_WIDTH:0]  mem_d [pDEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [pLVL_WIDTH-1:0] level_q, level_d;
  logic [31:0]           cur_len_q, cur_len_d;
  logic [31:0]           cur_sum_q, cur_sum_d;
  logic [31:0]           last_len_q, last_len_d;
  logic [31:0]           last_sum_q, last_sum_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  push, pop;

  // Ready depends on registered occupancy only: no pass-through when full.
  assign s_tready   = !axis_rst && (level_q != LVL_FULL);
  assign m_tvalid   = (level_q != '0);
  assign m_tdata    = mem_q[rd_ptr_q][pDATA_WIDTH-1:0];
  assign m_tlast    = mem_q[rd_ptr_q][pDATA_WIDTH];
  assign push       = s_tvalid && s_tready;
  assign pop        = m_tvalid && m_tready;
  assign level      = level_q;
  assign frame_cnt  = frame_cnt_q;
  assign last_len   = last_len_q;
  assign last_sum   = last_sum_q;
  assign frame_done = frame_done_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cur_len_d    = cur_len_q;
    cur_sum_d    = cur_sum_q;
    last_len_d   = last_len_q;
    last_sum_d   = last_sum_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (clear) begin
      for (int i = 0; i < pDEPTH; i++) mem_d[i] = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      cur_len_d   = '0;
      cur_sum_d   = '0;
      last_len_d  = '0;
      last_sum_d  = '0;
      frame_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {s_tlast, s_tdata};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (m_tlast) begin
          last_len_d   = cur_len_q + 32'd1;
          last_sum_d   = cur_sum_q + 32'(m_tdata);
          cur_len_d    = '0;
          cur_sum_d    = '0;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          frame_done_d = 1'b1;
        end else begin
          cur_len_d = cur_len_q + 32'd1;
          cur_sum_d = cur_sum_q + 32'(m_tdata);
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + pLVL_WIDTH'(1);
        2'b01:   level_d = level_q - pLVL_WIDTH'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      for (int i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cur_len_q    <= '0;
      cur_sum_q    <= '0;
      last_len_q   <= '0;
      last_sum_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cur_len_q    <= cur_len_d;
      cur_sum_q    <= cur_sum_d;
      last_len_q   <= last_len_d;
      last_sum_q   <= last_sum_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
